thr_timing_gen: RTL
===================

THR_TIMING_GEN -- requirements
Module: thr_timing_gen

Interface
- REQ-001 The module SHALL have parameter H_ACTIVE, default 480, meaning active pixels per line.
- REQ-002 The module SHALL have parameters H_FP 8, H_SYNC 4, H_BP 8, meaning horizontal front porch, sync and back porch in clocks.
- REQ-003 The module SHALL have parameters V_ACTIVE 272, V_FP 2, V_SYNC 2, V_BP 2, meaning vertical geometry in lines.
- REQ-004 The module SHALL have parameter SYNC_POL, default 1, meaning the asserted level of out_hs and out_vs.
- REQ-005 The module SHALL have port clk, input, 1 bit: the single clock.
- REQ-006 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
- REQ-007 The module SHALL have port en, input, 1 bit: request to run frames.
- REQ-008 The module SHALL have port pix_req, output, 1 bit: pixel fetch strobe to the upstream source.
- REQ-009 The module SHALL have port pix_in, input, 1 bit: binary pixel, valid the cycle after pix_req.
- REQ-010 The module SHALL have ports out_hs, out_vs, out_de and out_data, outputs, 1 bit each: the video stream consumed by the thr_* filters.
- REQ-011 The module SHALL have port busy, output, 1 bit: a frame is in progress.
- REQ-012 The module SHALL have port frame_cnt, output, 8 bits: completed-frame count.

Function
- REQ-013 Define H_TOTAL as H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL as V_ACTIVE+V_FP+V_SYNC+V_BP; h_cnt SHALL count 0..H_TOTAL-1, and v_cnt SHALL increment when h_cnt wraps, counting 0..V_TOTAL-1.
- REQ-014 Line order SHALL be active, front porch, sync, back porch, starting at count 0; both axes SHALL follow this order.
- REQ-015 pix_req SHALL be a combinational decode that is high when state is RUN/DRAIN, h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- REQ-016 Timing outputs SHALL be delayed exactly 2 clocks from the counter decode; out_data SHALL register pix_in, which gives out_data 2-cycle alignment with out_de.
- REQ-017 out_data SHALL be 0 whenever out_de is 0.
- REQ-018 out_vs SHALL be asserted for V_SYNC full lines; out_hs SHALL be asserted H_SYNC clocks on every line, including vertical blanking lines.
- REQ-019 The state machine SHALL have three states:
  - IDLE: counters held at 0, pix_req 0, outputs deasserted; en=1 moves to RUN on the next clock.
  - RUN: counters free-run; when en=0 is sampled, the state moves to DRAIN.
  - DRAIN: the current frame continues; at the last pixel of the frame (h=H_TOTAL-1, v=V_TOTAL-1) the state goes to IDLE if en=0, else back to RUN.
- REQ-020 Any en change SHALL be honoured only at frame boundaries; a frame is never truncated.
- REQ-021 At the last pixel of the frame in RUN, the counters SHALL wrap to 0 and continue seamlessly, with no idle cycle between frames.
- REQ-022 frame_cnt SHALL increment at each frame completion and wrap 255 to 0.
- REQ-023 busy SHALL be 1 in RUN/DRAIN; it SHALL be delayed 2 cycles so that it covers the output pipeline.

Reset
- REQ-024 rst SHALL force state IDLE, counters 0, frame_cnt 0, pixel and busy outputs 0, and pipeline contents deasserted.
- REQ-025 out_hs and out_vs SHALL reset to the deasserted level (!SYNC_POL).
- REQ-026 A rst asserted mid-frame SHALL abort that frame immediately; outputs SHALL be deasserted on the next clock.

Configuration
- REQ-027 With THR_TIMING_GEN_TPG_EN defined, an input tpg_sel (2 bits) SHALL select out_data: 0 = pix_in, 1 = checkerboard h_cnt[3]^v_cnt[3], 2 = vertical bars h_cnt[4], 3 = all ones; for sources 1–3, pix_req SHALL stay 0.
- REQ-028 Without THR_TIMING_GEN_TPG_EN, tpg_sel SHALL be absent and out_data SHALL always come from pix_in.

Structure
- REQ-029 Package thr_pkg SHALL hold the state enum (IDLE/RUN/DRAIN), the tpg_sel encoding constants, and the counter-width function clog2-based on the totals.
- REQ-030 There SHALL be one sub-module, thr_sync_delay (N-deep shift of {hs,vs,de,busy}), instantiated with N=2.

Verification
Bench parameters: H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1 (H_TOTAL=7); V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=5).
- REQ-031 rst then en=1 → pix_req first high 1 clock after en is sampled; out_de high 2 clocks later for 4 clocks per line, 2 lines; one frame = 35 clocks.
- REQ-032 pix_in pattern 1,0,1,1 each line → out_data 1,0,1,1 exactly coincident with out_de, and 0 elsewhere.
- REQ-033 en dropped at clock 10 of a frame → the frame completes all 35 clocks, then IDLE; frame_cnt=1; busy falls 2 clocks after the last count.
- REQ-034 en held for 256 frames → frame_cnt wraps to 0; no gap between consecutive frames, i.e. out_vs period exactly 35 clocks.
- REQ-035 rst pulsed at clock 17 → all outputs deasserted the next clock and frame_cnt=0; with en still 1, the frame restarts from h=v=0.
- REQ-036 (THR_TIMING_GEN_TPG_EN) tpg_sel=3 → out_data equals out_de and pix_req stays 0; tpg_sel=1 with H_ACTIVE=32 → out_data toggles every 8 pixels.

Source files
------------

// File: rtl/thr_pkg.sv
// Shared types and helpers for the thr_* video timing blocks.
package thr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } thr_state_e;

  localparam logic [1:0] TPG_PIX     = 2'd0;
  localparam logic [1:0] TPG_CHECKER = 2'd1;
  localparam logic [1:0] TPG_VBARS   = 2'd2;
  localparam logic [1:0] TPG_ONES    = 2'd3;

  function automatic int cnt_w(input int total);
    return (total < 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/thr_sync_delay.sv
// N-deep shift register for the {hs,vs,de,busy} timing bundle; cleared by rst.
module thr_sync_delay #(
  parameter int N = 2,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] dly_p [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) dly_p[i] <= '0;
    end else begin
      dly_p[0] <= d;
      for (int i = 1; i < N; i++) dly_p[i] <= dly_p[i-1];
    end
  end

  assign q = dly_p[N-1];

endmodule

// File: rtl/thr_timing_gen.sv
// Video timing generator: frame counters, en-gated run/drain FSM, 2-clock aligned outputs.
// Optional test-pattern source on out_data when THR_TIMING_GEN_TPG_EN is defined.
module thr_timing_gen
  import thr_pkg::*;
#(
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 4,
  parameter int H_BP     = 8,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 2,
  parameter int SYNC_POL = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       pix_req,
  input  logic       pix_in,
`ifdef THR_TIMING_GEN_TPG_EN
  input  logic [1:0] tpg_sel,
`endif
  output logic       out_hs,
  output logic       out_vs,
  output logic       out_de,
  output logic       out_data,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = cnt_w(H_TOTAL);
  localparam int VW      = cnt_w(V_TOTAL);
  localparam logic POL   = (SYNC_POL != 0);

  thr_state_e    state, state_nx;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [31:0]   h_pos, v_pos;
  logic          active, h_last, v_last, frame_end;
  logic          hs_p0, vs_p0, de_p0;
  logic          hs_p2, vs_p2, de_p2, busy_p2;
  logic          data_nx, data_p2;

  assign h_pos     = 32'(h_cnt);
  assign v_pos     = 32'(v_cnt);
  assign active    = (state != IDLE);
  assign h_last    = (h_pos == H_TOTAL - 1);
  assign v_last    = (v_pos == V_TOTAL - 1);
  assign frame_end = active && h_last && v_last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // en only takes effect at a frame boundary; a frame is never cut short.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (en) state_nx = RUN;
      RUN:     if (!en) state_nx = frame_end ? IDLE : DRAIN;
      DRAIN:   if (frame_end) state_nx = en ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !active) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            frame_cnt <= 8'd0;
    else if (frame_end) frame_cnt <= frame_cnt + 8'd1;
  end

  // p0: decode from the live counters
  assign de_p0 = active && (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
  assign hs_p0 = active && (h_pos >= H_ACTIVE + H_FP) && (h_pos < H_ACTIVE + H_FP + H_SYNC);
  assign vs_p0 = active && (v_pos >= V_ACTIVE + V_FP) && (v_pos < V_ACTIVE + V_FP + V_SYNC);

`ifdef THR_TIMING_GEN_TPG_EN
  logic tpg_p0, tpg_p1, sel_pix_p1;

  assign pix_req = de_p0 && (tpg_sel == TPG_PIX);

  always_comb begin
    tpg_p0 = 1'b0;
    case (tpg_sel)
      TPG_CHECKER: tpg_p0 = h_pos[3] ^ v_pos[3];
      TPG_VBARS:   tpg_p0 = h_pos[4];
      TPG_ONES:    tpg_p0 = 1'b1;
      default:     tpg_p0 = 1'b0;
    endcase
  end

  // p1: pattern bit waits one clock so it lines up with the fetched pix_in
  always_ff @(posedge clk) begin
    if (rst) begin
      tpg_p1     <= 1'b0;
      sel_pix_p1 <= 1'b1;
    end else begin
      tpg_p1     <= tpg_p0;
      sel_pix_p1 <= (tpg_sel == TPG_PIX);
    end
  end

  assign data_nx = sel_pix_p1 ? pix_in : tpg_p1;
`else
  assign pix_req = de_p0;
  assign data_nx = pix_in;
`endif

  thr_sync_delay #(.N(2), .W(4)) u_sync_delay (
    .clk (clk),
    .rst (rst),
    .d   ({hs_p0, vs_p0, de_p0, active}),
    .q   ({hs_p2, vs_p2, de_p2, busy_p2})
  );

  // p2: pixel lands here, aligned with the delayed timing bundle
  always_ff @(posedge clk) begin
    if (rst) data_p2 <= 1'b0;
    else     data_p2 <= data_nx;
  end

  assign out_hs   = hs_p2 ? POL : ~POL;
  assign out_vs   = vs_p2 ? POL : ~POL;
  assign out_de   = de_p2;
  assign out_data = data_p2 & de_p2;
  assign busy     = busy_p2;

endmodule
